// File: rtl/sfx_sequencer.sv
// sfx_sequencer
//   Plays one of four short sound effects on the piezo buzzer. The effects
//   live in a small note ROM, and a single tone generator plays them. A
//   trigger for a lower-numbered effect pre-empts a higher-numbered one that
//   is already playing. stop aborts the current effect and mute silences the
//   output without changing the timing.
//
//   Optional build macro NOTE_GAP_EN inserts one tick of silence between the
//   consecutive notes of an effect.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   trig     in   [3:0] per-effect request, rising-edge detected; bit 0 wins
//   stop     in   abort the current effect (no done pulse)
//   mute     in   gates buzz to 0, sequencing unaffected
//   buzz     out  square-wave tone
//   busy     out  high while an effect is playing
//   cur_sfx  out  [1:0] effect index, holds last value when idle
//   done     out  one-cycle pulse on natural completion
//
// state  | meaning
// IDLE   | nothing playing, waiting for a trigger edge
// LOAD   | fetch note, reset tone and duration counters (1 cycle)
// PLAY   | tone running for dur*TICK_DIV cycles
// GAP    | one tick of silence between notes (NOTE_GAP_EN only)
// FINISH | done pulse, busy already low; accepts a new trigger
module sfx_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int MAX_NOTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] trig,
  input  logic       stop,
  input  logic       mute,
  output logic       buzz,
  output logic       busy,
  output logic [1:0] cur_sfx,
  output logic       done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV + 1);
  // the lowest pitch (262 Hz) has the longest half period
  localparam int TONE_W   = $clog2(CLK_HZ / (2 * 262) + 1);
  localparam int IDX_W    = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

  localparam logic [3:0] F_REST = 4'd0;
  localparam logic [3:0] F_262  = 4'd1;
  localparam logic [3:0] F_330  = 4'd2;
  localparam logic [3:0] F_349  = 4'd3;
  localparam logic [3:0] F_392  = 4'd4;
  localparam logic [3:0] F_466  = 4'd5;
  localparam logic [3:0] F_523  = 4'd6;
  localparam logic [3:0] F_659  = 4'd7;
  localparam logic [3:0] F_784  = 4'd8;
  localparam logic [3:0] F_880  = 4'd9;
  localparam logic [3:0] F_1047 = 4'd10;

  // ROM word = {freq select, duration in ticks}; all-ones marks end of effect
  localparam logic [9:0] NOTE_END = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_FINISH
  } state_t;

  function automatic logic [9:0] note(input logic [3:0] sel, input int dur);
    return {sel, 6'(dur)};
  endfunction

  function automatic logic [9:0] rom_entry(input logic [1:0] sfx,
                                           input logic [IDX_W-1:0] idx);
    logic [9:0] e;
    e = NOTE_END;
    case (sfx)
      2'd0: begin
        case (int'(idx))
          0:       e = note(F_523, 8);
          1:       e = note(F_466, 8);
          2:       e = note(F_392, 8);
          default: e = NOTE_END;
        endcase
      end
      2'd1: begin
        case (int'(idx))
          0:       e = note(F_880, 4);
          1:       e = note(F_REST, 2);
          2:       e = note(F_880, 4);
          default: e = NOTE_END;
        endcase
      end
      2'd2: begin
        case (int'(idx))
          0:       e = note(F_523, 6);
          1:       e = note(F_659, 6);
          2:       e = note(F_784, 6);
          3:       e = note(F_1047, 6);
          default: e = NOTE_END;
        endcase
      end
      default: begin
        case (int'(idx))
          0:       e = note(F_392, 40);
          1:       e = note(F_349, 40);
          2:       e = note(F_330, 40);
          3:       e = note(F_262, 40);
          default: e = NOTE_END;
        endcase
      end
    endcase
    return e;
  endfunction

  // tone counter reload value: half period minus one
  function automatic logic [TONE_W-1:0] half_period_m1(input logic [3:0] sel);
    logic [TONE_W-1:0] h;
    case (sel)
      F_262:   h = TONE_W'(CLK_HZ / (2 * 262) - 1);
      F_330:   h = TONE_W'(CLK_HZ / (2 * 330) - 1);
      F_349:   h = TONE_W'(CLK_HZ / (2 * 349) - 1);
      F_392:   h = TONE_W'(CLK_HZ / (2 * 392) - 1);
      F_466:   h = TONE_W'(CLK_HZ / (2 * 466) - 1);
      F_523:   h = TONE_W'(CLK_HZ / (2 * 523) - 1);
      F_659:   h = TONE_W'(CLK_HZ / (2 * 659) - 1);
      F_784:   h = TONE_W'(CLK_HZ / (2 * 784) - 1);
      F_880:   h = TONE_W'(CLK_HZ / (2 * 880) - 1);
      F_1047:  h = TONE_W'(CLK_HZ / (2 * 1047) - 1);
      default: h = '0;
    endcase
    return h;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        trig_prev_q, trig_prev_d;
  logic [1:0]        cur_sfx_q, cur_sfx_d;
  logic [IDX_W-1:0]  note_idx_q, note_idx_d;
  logic [3:0]        freq_sel_q, freq_sel_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [5:0]        ticks_left_q, ticks_left_d;
  logic              buzz_q, buzz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0] trig_edge;
  logic       any_edge;
  logic [1:0] winner;
  logic [9:0] entry;
  logic [9:0] next_entry;
  logic       last_note;
  logic       play_end;
  logic       playing;

  always_comb begin
    trig_prev_d  = trig;
    state_d      = state_q;
    cur_sfx_d    = cur_sfx_q;
    note_idx_d   = note_idx_q;
    freq_sel_d   = freq_sel_q;
    tone_cnt_d   = tone_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    ticks_left_d = ticks_left_q;
    buzz_d       = buzz_q;

    trig_edge = trig & ~trig_prev_q;
    any_edge  = |trig_edge;
    if (trig_edge[0])      winner = 2'd0;
    else if (trig_edge[1]) winner = 2'd1;
    else if (trig_edge[2]) winner = 2'd2;
    else                   winner = 2'd3;

    entry      = rom_entry(cur_sfx_q, note_idx_q);
    next_entry = rom_entry(cur_sfx_q, note_idx_q + IDX_W'(1));
    last_note  = (note_idx_q == IDX_W'(MAX_NOTES - 1)) || (next_entry == NOTE_END);
    play_end   = (tick_cnt_q == '0) && (ticks_left_q == '0);
    playing    = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);

    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (any_edge) begin
          state_d    = S_LOAD;
          cur_sfx_d  = winner;
          note_idx_d = '0;
        end
      end
      S_LOAD: begin
        freq_sel_d   = entry[9:6];
        tone_cnt_d   = half_period_m1(entry[9:6]);
        tick_cnt_d   = TICK_W'(TICK_DIV - 1);
        ticks_left_d = entry[5:0] - 6'd1;
        buzz_d       = 1'b0;
        state_d      = S_PLAY;
      end
      S_PLAY: begin
        if (freq_sel_q == F_REST) begin
          buzz_d = 1'b0;
        end else if (tone_cnt_q == '0) begin
          tone_cnt_d = half_period_m1(freq_sel_q);
          buzz_d     = ~buzz_q;
        end else begin
          tone_cnt_d = tone_cnt_q - TONE_W'(1);
        end

        // tick prescaler feeding the per-note tick count
        if (tick_cnt_q == '0) begin
          tick_cnt_d = TICK_W'(TICK_DIV - 1);
          if (ticks_left_q != '0) ticks_left_d = ticks_left_q - 6'd1;
        end else begin
          tick_cnt_d = tick_cnt_q - TICK_W'(1);
        end

        if (play_end) begin
          buzz_d = 1'b0;
          if (last_note) begin
            state_d = S_FINISH;
          end else begin
            note_idx_d = note_idx_q + IDX_W'(1);
`ifdef NOTE_GAP_EN
            tick_cnt_d = TICK_W'(TICK_DIV - 1);
            state_d    = S_GAP;
`else
            state_d    = S_LOAD;
`endif
          end
        end
      end
      S_GAP: begin
        buzz_d = 1'b0;
        if (tick_cnt_q == '0) state_d = S_LOAD;
        else tick_cnt_d = tick_cnt_q - TICK_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // stop beats any same-cycle trigger; only a lower index may pre-empt
    if (playing) begin
      if (stop) begin
        state_d = S_IDLE;
        buzz_d  = 1'b0;
      end else if (any_edge && (winner < cur_sfx_q)) begin
        state_d    = S_LOAD;
        cur_sfx_d  = winner;
        note_idx_d = '0;
        buzz_d     = 1'b0;
      end
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_PLAY) || (state_d == S_GAP);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      trig_prev_q  <= '0;
      cur_sfx_q    <= '0;
      note_idx_q   <= '0;
      freq_sel_q   <= '0;
      tone_cnt_q   <= '0;
      tick_cnt_q   <= '0;
      ticks_left_q <= '0;
      buzz_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_prev_q  <= trig_prev_d;
      cur_sfx_q    <= cur_sfx_d;
      note_idx_q   <= note_idx_d;
      freq_sel_q   <= freq_sel_d;
      tone_cnt_q   <= tone_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      ticks_left_q <= ticks_left_d;
      buzz_q       <= buzz_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign buzz    = buzz_q & ~mute;
  assign busy    = busy_q;
  assign cur_sfx = cur_sfx_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer at CLK_HZ=1 MHz, TICK_HZ=1 kHz (1000 cycles/tick).
// A note-list model predicts busy/done/cur_sfx/buzz every cycle from the
// time elapsed since an effect started; literal checks pin key timings.
module tb_sfx_sequencer;

  localparam int CLK_HZ   = 1_000_000;
  localparam int TICK_HZ  = 1000;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
`ifdef NOTE_GAP_EN
  localparam int GAP_CYC = TICK_DIV;
`else
  localparam int GAP_CYC = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] trig;
  logic       stop;
  logic       mute;
  logic       buzz;
  logic       busy;
  logic [1:0] cur_sfx;
  logic       done;

  sfx_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .MAX_NOTES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trig   (trig),
    .stop   (stop),
    .mute   (mute),
    .buzz   (buzz),
    .busy   (busy),
    .cur_sfx(cur_sfx),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  // effect note lists: frequency in Hz (0 = rest) and duration in ticks
  int freq_tab [4][4] = '{'{523, 466, 392, 0},
                          '{880, 0, 880, 0},
                          '{523, 659, 784, 1047},
                          '{392, 349, 330, 262}};
  int dur_tab  [4][4] = '{'{8, 8, 8, 0},
                          '{4, 2, 4, 0},
                          '{6, 6, 6, 6},
                          '{40, 40, 40, 40}};
  int nnotes   [4]    = '{3, 3, 4, 4};

  // expected outputs e cycles after an effect entered its first LOAD cycle
  function automatic void eval_model(input int e, input int sfx,
                                     output bit b, output bit bz, output bit d);
    int pos, len, h, nn, f;
    bit hit;
    pos = e; b = 0; bz = 0; d = 0; hit = 0;
    nn = nnotes[sfx];
    for (int n = 0; n < nn; n++) begin
      if (!hit) begin
        len = 1 + dur_tab[sfx][n] * TICK_DIV;
        f   = freq_tab[sfx][n];
        if (pos < len) begin
          hit = 1;
          b   = 1;
          if (pos > 0 && f != 0) begin
            h  = CLK_HZ / (2 * f);
            bz = (((pos - 1) / h) % 2) == 1;
          end
        end else begin
          pos = pos - len;
          if (n < nn - 1) begin
            if (pos < GAP_CYC) begin
              hit = 1;
              b   = 1;
            end else begin
              pos = pos - GAP_CYC;
            end
          end
        end
      end
    end
    if (!hit) d = (pos == 0);
  endfunction

  int         m_cyc;
  int         m_start;
  bit         m_active;
  int         m_sfx;
  logic [3:0] m_prev;
  bit         e_busy, e_buzz, e_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_start = 0; m_active = 0; m_sfx = 0; m_prev = '0;
      e_busy = 0; e_buzz = 0; e_done = 0;
    end else begin
      bit b, bz, d;
      logic [3:0] edges;
      int w;
      b = 0; bz = 0; d = 0;
      if (m_active) eval_model(m_cyc - m_start, m_sfx, b, bz, d);
      edges  = trig & ~m_prev;
      m_prev = trig;
      w = 4;
      for (int i = 3; i >= 0; i--) if (edges[i]) w = i;
      if (b) begin
        if (stop) m_active = 0;
        else if (w < m_sfx) begin
          m_sfx = w; m_start = m_cyc + 1;
        end
      end else if (w < 4) begin
        m_active = 1; m_sfx = w; m_start = m_cyc + 1;
      end else begin
        m_active = 0;
      end
      m_cyc = m_cyc + 1;
      e_busy = 0; e_buzz = 0; e_done = 0;
      if (m_active) eval_model(m_cyc - m_start, m_sfx, e_busy, e_buzz, e_done);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic [4:0] act, req;
      act = {busy, done, cur_sfx, buzz};
      req = {e_busy, e_done, 2'(m_sfx), e_buzz & ~mute};
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL cycle_model cyc=%0d busy/done/cur_sfx/buzz actual=%b required=%b",
                    m_cyc, act, req);
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; trig = '0; stop = 1'b0; mute = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_buzz", int'(buzz), 0);
    check("rst_cur_sfx", int'(cur_sfx), 0);
    tick(5);

    // SFX0 full run
    trig = 4'b0001; tick(1); trig = '0;
    k = 0;
    check("a_busy", int'(busy), 1);
    check("a_cur_sfx", int'(cur_sfx), 0);
    while (!buzz && k < 3000) begin tick(1); k++; end
    check("a_first_half_period", k, 957);
    while (!done && k < 40000) begin tick(1); k++; end
    check("a_done_cycle", k, 24003 + 2 * GAP_CYC);
    check("a_busy_at_done", int'(busy), 0);
    tick(1);
    check("a_done_single", int'(done), 0);
    tick(20);

    // SFX1 with a rest note; first note muted
    mute = 1'b1;
    trig = 4'b0010; tick(1); trig = '0;
    k = 0;
    check("b_cur_sfx", int'(cur_sfx), 1);
    while (!done && k < 20000) begin
      tick(1); k++;
      if (k == 3000) mute = 1'b0;
    end
    check("b_done_cycle", k, 10003 + 2 * GAP_CYC);
    tick(20);

    // SFX3 pre-empted by SFX0, ignored SFX2 retrigger, then stop
    trig = 4'b1000; tick(1); trig = '0;
    check("c_cur_sfx3", int'(cur_sfx), 3);
    tick(20000);
    trig = 4'b0001; tick(1); trig = '0;
    check("c_preempt_cur", int'(cur_sfx), 0);
    check("c_preempt_busy", int'(busy), 1);
    k = 0;
    while (!buzz && k < 3000) begin tick(1); k++; end
    check("c_preempt_half_period", k, 957);
    tick(4000);
    trig = 4'b0100; tick(1); trig = '0;
    check("c_ignore_lower_prio", int'(cur_sfx), 0);
    tick(3000);
    stop = 1'b1; tick(1); stop = 1'b0;
    check("c_stop_busy", int'(busy), 0);
    check("c_stop_buzz", int'(buzz), 0);
    tick(50);

    // simultaneous edges, then stop together with a trigger
    trig = 4'b1010; tick(1); trig = '0;
    check("d_simul_cur", int'(cur_sfx), 1);
    tick(1500);
    stop = 1'b1; trig = 4'b0001; tick(1); stop = 1'b0; trig = '0;
    check("d_stop_wins_busy", int'(busy), 0);
    tick(2);
    check("d_stays_idle", int'(busy), 0);
    tick(20);

    // async reset mid-effect; trig held through release counts as an edge
    trig = 4'b0100; tick(1); trig = '0;
    tick(3000);
    reset = 1'b1;
    #1;
    check("e_rst_busy", int'(busy), 0);
    check("e_rst_buzz", int'(buzz), 0);
    check("e_rst_cur_sfx", int'(cur_sfx), 0);
    check("e_rst_done", int'(done), 0);
    trig = 4'b0100;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("e_post_rst_busy", int'(busy), 1);
    check("e_post_rst_cur", int'(cur_sfx), 2);
    trig = '0;
    tick(2000);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(10);

    // random triggers, stops and mute
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 299));
      if (r == 0) trig = 4'($urandom_range(0, 15));
      else if (r < 6) trig = '0;
      stop = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      tick(1);
    end
    trig = '0; stop = 1'b0; mute = 1'b0;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
